// File: rtl/seg7_pkg.sv
// seg7_pkg: shared glyph constants and FSM state type for the seven-segment decoder.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
// Patterns are active-low, bit6=g .. bit0=a (0 = segment lit).
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b0000011;
  localparam logic [6:0] SEG_C     = 7'b1000110;
  localparam logic [6:0] SEG_D     = 7'b0100001;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_F     = 7'b0001110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // TRACK: filtering, no result shown. PRESENT: result held until consumed.
  typedef enum logic {
    ST_TRACK   = 1'b0,
    ST_PRESENT = 1'b1
  } state_e;

endpackage

// File: rtl/seg7_pattern_lookup.sv
// seg7_pattern_lookup: maps a 7-bit active-low segment pattern to its hex digit.
// Latency: combinational.
// Backpressure: none.
// Ports: pattern (in, 7b); value (out, 4b, 0 on miss); hit (out, legal glyph); blank (out, all segments off).
module seg7_pattern_lookup
  import seg7_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] value,
  output logic       hit,
  output logic       blank
);

  always_comb begin
    value = 4'h0;
    hit   = 1'b1;
    blank = (pattern == SEG_BLANK);
    case (pattern)
      SEG_0:   value = 4'h0;
      SEG_1:   value = 4'h1;
      SEG_2:   value = 4'h2;
      SEG_3:   value = 4'h3;
      SEG_4:   value = 4'h4;
      SEG_5:   value = 4'h5;
      SEG_6:   value = 4'h6;
      SEG_7:   value = 4'h7;
      SEG_8:   value = 4'h8;
      SEG_9:   value = 4'h9;
      SEG_A:   value = 4'hA;
      SEG_B:   value = 4'hB;
      SEG_C:   value = 4'hC;
      SEG_D:   value = 4'hD;
      SEG_E:   value = 4'hE;
      SEG_F:   value = 4'hF;
      default: hit   = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_encoder.sv
// seg7_encoder: debounces a seven-segment pattern and emits each newly stable glyph once as a hex digit.
// Latency: out_valid rises STABLE_CYCLES-1 edges after a pattern is first sampled.
// Backpressure: out_valid/out_value/out_err hold until out_ready; one newer result is parked meanwhile.
// Ports: clock, resetn (async active-low), seg_in[6:0] (active-low, bit0=a..bit6=g),
//        out_value[3:0], out_err, out_valid, out_ready.
// Build option: define SEG7_ENCODER_ERR_EN to report illegal glyphs with out_err=1; otherwise they are ignored.
module seg7_encoder
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic [6:0] seg_in,
  output logic [3:0] out_value,
  output logic       out_err,
  output logic       out_valid,
  input  logic       out_ready
);

  localparam logic [3:0] CNT_MAX = 4'(STABLE_CYCLES - 1);
  localparam logic [3:0] CNT_PRE = 4'(STABLE_CYCLES - 2);

  logic [6:0] seg_q, seg_d;
  logic [3:0] cnt_q, cnt_d;
  logic [6:0] last_q, last_d;
  state_e     state_q, state_d;
  logic       pend_vld_q, pend_vld_d;
  logic [3:0] pend_val_q, pend_val_d;
  logic       pend_err_q, pend_err_d;
  logic [3:0] val_q, val_d;
  logic       err_q, err_d;
  logic       vld_q, vld_d;

  logic [3:0] lk_value;
  logic       lk_hit;
  logic       lk_blank;
  logic       same;
  logic       accept;
  logic       emit_ok;
  logic [3:0] new_val;
  logic       new_err;

  seg7_pattern_lookup u_lookup (
    .pattern (seg_q),
    .value   (lk_value),
    .hit     (lk_hit),
    .blank   (lk_blank)
  );

  assign same   = (seg_in == seg_q);
  // cnt is about to reach its terminal value on this edge: seg_q is accepted now.
  // Once saturated it stays put, so a held pattern is accepted only once.
  assign accept = same && (cnt_q == CNT_PRE);

`ifdef SEG7_ENCODER_ERR_EN
  assign emit_ok = accept && !lk_blank && (seg_q != last_q);
  assign new_val = lk_hit ? lk_value : 4'h0;
  assign new_err = !lk_hit;
`else
  assign emit_ok = accept && lk_hit && (seg_q != last_q);
  assign new_val = lk_value;
  assign new_err = 1'b0;
`endif

  always_comb begin
    seg_d      = seg_in;
    cnt_d      = 4'd0;
    last_d     = last_q;
    state_d    = state_q;
    pend_vld_d = pend_vld_q;
    pend_val_d = pend_val_q;
    pend_err_d = pend_err_q;
    val_d      = val_q;
    err_d      = err_q;
    vld_d      = vld_q;

    if (same) begin
      cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 4'd1;
    end

    // A stable blank re-arms the digit it interrupted without emitting anything.
    if (accept && lk_blank) begin
      last_d = SEG_BLANK;
    end
    if (emit_ok) begin
      last_d = seg_q;
    end

    case (state_q)
      ST_TRACK: begin
        // A fresh acceptance is newer than anything parked, so it wins.
        if (emit_ok) begin
          val_d      = new_val;
          err_d      = new_err;
          vld_d      = 1'b1;
          pend_vld_d = 1'b0;
          state_d    = ST_PRESENT;
        end else if (pend_vld_q) begin
          val_d      = pend_val_q;
          err_d      = pend_err_q;
          vld_d      = 1'b1;
          pend_vld_d = 1'b0;
          state_d    = ST_PRESENT;
        end
      end
      ST_PRESENT: begin
        if (emit_ok) begin
          pend_vld_d = 1'b1;
          pend_val_d = new_val;
          pend_err_d = new_err;
        end
        if (out_ready) begin
          vld_d   = 1'b0;
          state_d = ST_TRACK;
        end
      end
      default: begin
        vld_d   = 1'b0;
        state_d = ST_TRACK;
      end
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      seg_q      <= SEG_BLANK;
      cnt_q      <= 4'd0;
      last_q     <= SEG_BLANK;
      state_q    <= ST_TRACK;
      pend_vld_q <= 1'b0;
      pend_val_q <= 4'h0;
      pend_err_q <= 1'b0;
      val_q      <= 4'h0;
      err_q      <= 1'b0;
      vld_q      <= 1'b0;
    end else begin
      seg_q      <= seg_d;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
      state_q    <= state_d;
      pend_vld_q <= pend_vld_d;
      pend_val_q <= pend_val_d;
      pend_err_q <= pend_err_d;
      val_q      <= val_d;
      err_q      <= err_d;
      vld_q      <= vld_d;
    end
  end

  assign out_value = val_q;
  assign out_err   = err_q;
  assign out_valid = vld_q;

endmodule

// File: tb/tb_seg7_encoder.sv
// tb_seg7_encoder: directed bench for seg7_encoder with STABLE_CYCLES=4.
// Latency: results expected on the 4th sampling edge of a new stable pattern.
// Backpressure: exercised by holding out_ready low across a second acceptance.
module tb_seg7_encoder;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic [6:0] seg_in = 7'b1111111;
  logic       out_ready = 1'b0;
  logic [3:0] out_value;
  logic       out_err;
  logic       out_valid;

  int         checks = 0;
  int         errors = 0;

  // Results of the most recent run(): valid samples seen, index/value of the first.
  int         nvld;
  int         first_idx;
  logic [3:0] first_val;
  logic       first_err;

  seg7_encoder dut (
    .clock     (clock),
    .resetn    (resetn),
    .seg_in    (seg_in),
    .out_value (out_value),
    .out_err   (out_err),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Drive pat for n edges, sampling outputs 1 ns after each edge.
  task automatic run(input logic [6:0] pat, input int n);
    seg_in    = pat;
    nvld      = 0;
    first_idx = 0;
    first_val = 4'h0;
    first_err = 1'b0;
    for (int i = 1; i <= n; i++) begin
      step();
      if (out_valid) begin
        if (nvld == 0) begin
          first_idx = i;
          first_val = out_value;
          first_err = out_err;
        end
        nvld++;
      end
    end
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_valid", out_valid, 0);
    check("rst_value", out_value, 4'h0);
    check("rst_err", out_err, 0);
    step();
    resetn = 1'b1;
    out_ready = 1'b1;

    // Blank never produces a result
    run(7'b1111111, 6);
    check("blank_none", nvld, 0);

    // Digit 2 held 10 cycles: one result on the 4th sampling edge
    run(7'b0100100, 10);
    check("d2_count", nvld, 1);
    check("d2_idx", first_idx, 4);
    check("d2_value", first_val, 4'h2);
    check("d2_err", first_err, 0);

    // Digit 6 interrupted by a one-cycle blank one edge before acceptance
    run(7'b0000010, 3);
    check("d6_pre_none", nvld, 0);
    run(7'b1111111, 1);
    check("d6_glitch_none", nvld, 0);
    run(7'b0000010, 10);
    check("d6_count", nvld, 1);
    check("d6_idx", first_idx, 4);
    check("d6_value", first_val, 4'h6);

    // Digit 5, blank, digit 5 again: two results, no blank result
    run(7'b0010010, 6);
    check("d5a_count", nvld, 1);
    check("d5a_value", first_val, 4'h5);
    run(7'b1111111, 6);
    check("d5_blank_none", nvld, 0);
    run(7'b0010010, 6);
    check("d5b_count", nvld, 1);
    check("d5b_idx", first_idx, 4);
    check("d5b_value", first_val, 4'h5);

    // Backpressure: 8 presented and held while 1 becomes stable
    out_ready = 1'b0;
    run(7'b0000000, 6);
    check("d8_idx", first_idx, 4);
    check("d8_count", nvld, 3);
    check("d8_value", first_val, 4'h8);
    run(7'b1111001, 6);
    check("d8_held_count", nvld, 6);
    check("d8_held_value", out_value, 4'h8);
    out_ready = 1'b1;
    step();
    check("d8_consumed", out_valid, 0);
    step();
    check("d1_pending_valid", out_valid, 1);
    check("d1_pending_value", out_value, 4'h1);
    step();
    check("d1_consumed", out_valid, 0);

    // Asynchronous reset while a result is held
    out_ready = 1'b0;
    run(7'b1111000, 5);
    check("d7_idx", first_idx, 4);
    check("d7_held", out_valid, 1);
    resetn = 1'b0;
    #2;
    check("arst_valid", out_valid, 0);
    check("arst_value", out_value, 4'h0);
    step();
    step();
    resetn = 1'b1;
    out_ready = 1'b1;
    run(7'b1111000, 6);
    check("d7_re_count", nvld, 1);
    check("d7_re_idx", first_idx, 4);
    check("d7_re_value", first_val, 4'h7);

    // Illegal glyph
    run(7'b0110110, 8);
`ifdef SEG7_ENCODER_ERR_EN
    check("ill_count", nvld, 1);
    check("ill_err", first_err, 1);
    check("ill_value", first_val, 4'h0);
`else
    check("ill_none", nvld, 0);
    check("ill_err_low", out_err, 0);
`endif

    // Digit E after a glitch one edge before acceptance
    run(7'b0000110, 3);
    run(7'b0100100, 1);
    run(7'b0000110, 6);
    check("dE_count", nvld, 1);
    check("dE_idx", first_idx, 4);
    check("dE_value", first_val, 4'hE);
    check("dE_err", first_err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
